inst_fetch_ctrl: RTL and testbench
==================================

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 6'h01, the first fetch address after reset (address 0 is reserved empty).
REQ-002 The block SHALL have parameter CNT_W, default 8, the width of the performance counters.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-005 The block SHALL have port stall, input, 1, hazard-unit request to hold PC and IF/ID.
REQ-006 The block SHALL have port branch_taken, input, 1, redirect request from the branch-resolve stage.
REQ-007 The block SHALL have port branch_target, input, 6, redirect address.
REQ-008 The block SHALL have port rom_inst, input, 32, instruction word returned combinationally by the instruction ROM.
REQ-009 The block SHALL have port rom_addr, output, 6, instruction ROM address (= PC register).
REQ-010 The block SHALL have port if_id_inst, output, 32, registered IF/ID instruction.
REQ-011 The block SHALL have port if_id_pc, output, 6, registered address of if_id_inst.
REQ-012 The block SHALL have port if_id_valid, output, 1, if_id_inst is a real fetched instruction.
REQ-013 The block SHALL have port halted, output, 1, high in HALT state.
REQ-014 The block SHALL have port stall_cnt, output, CNT_W, saturating count of stalled RUN cycles.
REQ-015 The block SHALL have port fetch_cnt, output, CNT_W, saturating count of instructions latched into IF/ID.

Function
REQ-016 The state machine SHALL have exactly three states: IDLE, RUN and HALT.
REQ-017 rom_addr SHALL equal the PC register combinationally at all times.
REQ-018 In IDLE, one cycle after reset: no fetch, IF/ID holds its reset value, next state RUN.
REQ-019 In RUN, the update priority per edge SHALL be branch_taken > stall > normal fetch.
REQ-020 RUN, normal fetch (stall=0, branch_taken=0): if_id_inst<=rom_inst; if_id_pc<=PC; if_id_valid<=1; PC<=PC+1; fetch_cnt increments.
REQ-021 RUN, stall=1 and branch_taken=0: PC, if_id_inst, if_id_pc and if_id_valid SHALL hold; stall_cnt increments.
REQ-022 RUN, branch_taken=1: PC<=branch_target; IF/ID flushed (if_id_inst<=0, if_id_pc<=0, if_id_valid<=0), regardless of stall; no counter change.
REQ-023 RUN, normal fetch at PC=6'h3F: the instruction is latched as in REQ-020, PC holds at 6'h3F (no wrap to 0), and next state is HALT.
REQ-024 In HALT, with branch_taken=0: PC holds; IF/ID is flushed to 0 and invalid from the first HALT edge onward; stall is ignored; halted=1.
REQ-025 In HALT, branch_taken=1: PC<=branch_target, IF/ID stays flushed, and the next state is RUN.
REQ-026 Both counters SHALL saturate at all-ones and never wrap.
REQ-027 One fetch SHALL have one cycle of latency: the instruction at address A appears on if_id_inst on the edge after rom_addr=A with no stall.

Reset
REQ-028 On any rising edge with rst_n=0, regardless of state or other inputs (including mid-stall, mid-branch or in HALT), the block SHALL set PC=RESET_PC, state=IDLE, if_id_inst=0, if_id_pc=0, if_id_valid=0, halted=0, stall_cnt=0 and fetch_cnt=0.
REQ-029 While rst_n=0 the outputs SHALL remain at their reset values; the first fetch occurs on the second edge after rst_n rises.

Verification
REQ-030 Reset then run (bench ROM loaded with the standard test program): after the IDLE cycle, rom_addr=6'h01; next edge -> if_id_inst=32'h28033046, if_id_pc=6'h01, valid=1, rom_addr=6'h02.
REQ-031 Stall: stall=1 for 2 cycles with rom_addr=6'h03 -> if_id_inst holds 32'h38000866, PC holds 6'h03, stall_cnt=2; release -> if_id_inst=32'h14002d29.
REQ-032 Branch: branch_taken=1, branch_target=6'h0A, with stall=1 simultaneously -> valid=0, if_id_inst=0, rom_addr=6'h0A; next edge -> if_id_inst=32'h00101464, if_id_pc=6'h0A.
REQ-033 End of ROM: branch to 6'h3F then run -> if_id_pc=6'h3F latched, halted=1 next, PC stays 6'h3F, valid=0 thereafter; branch to 6'h01 -> halted=0, fetch resumes.
REQ-034 Reset mid-operation: rst_n=0 for one edge during a stall in RUN -> all outputs at reset values; fetch resumes from 6'h01 after the IDLE cycle.
REQ-035 Saturation: preload or run 260 fetches with CNT_W=8 -> fetch_cnt=8'hFF and does not wrap.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: drives the PC and the IF/ID register through a three-state FSM.
// It also keeps saturating counts of stalled RUN cycles and of instructions latched into IF/ID.
module inst_fetch_ctrl #(
  parameter logic [5:0] RESET_PC = 6'h01,
  parameter int         CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [5:0]       branch_target,
  input  logic [31:0]      rom_inst,
  output logic [5:0]       rom_addr,
  output logic [31:0]      if_id_inst,
  output logic [5:0]       if_id_pc,
  output logic             if_id_valid,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

  state_e             state_q, state_d;
  logic [5:0]         pc_q, pc_d;
  logic [31:0]        inst_q, inst_d;
  logic [5:0]         ifpc_q, ifpc_d;
  logic               vld_q, vld_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      ifpc_q      <= '0;
      vld_q       <= 1'b0;
      stall_cnt_q <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      ifpc_q      <= ifpc_d;
      vld_q       <= vld_d;
      stall_cnt_q <= stall_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN:  if (!branch_taken && !stall && pc_q == 6'h3F) state_d = HALT;
      HALT: if (branch_taken) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Branch beats stall beats fetch; the last address latches but does not wrap.
  always_comb begin
    pc_d        = pc_q;
    inst_d      = inst_q;
    ifpc_d      = ifpc_q;
    vld_d       = vld_q;
    stall_cnt_d = stall_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    case (state_q)
      RUN: begin
        if (branch_taken) begin
          pc_d   = branch_target;
          inst_d = '0;
          ifpc_d = '0;
          vld_d  = 1'b0;
        end else if (stall) begin
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
          inst_d = rom_inst;
          ifpc_d = pc_q;
          vld_d  = 1'b1;
          if (pc_q != 6'h3F) pc_d = pc_q + 6'd1;
          if (fetch_cnt_q != '1) fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end
      end
      HALT: begin
        inst_d = '0;
        ifpc_d = '0;
        vld_d  = 1'b0;
        if (branch_taken) pc_d = branch_target;
      end
      default: ;
    endcase
  end

  always_comb begin
    halted      = (state_q == HALT);
    rom_addr    = pc_q;
    if_id_inst  = inst_q;
    if_id_pc    = ifpc_q;
    if_id_valid = vld_q;
    stall_cnt   = stall_cnt_q;
    fetch_cnt   = fetch_cnt_q;
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: reset, fetch, stall, branch, end-of-ROM halt,
// mid-stall reset and counter saturation, checked against hand-computed values.
module tb_inst_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, stall, branch_taken;
  logic [5:0]  branch_target;
  logic [31:0] rom_inst;
  logic [5:0]  rom_addr;
  logic [31:0] if_id_inst;
  logic [5:0]  if_id_pc;
  logic        if_id_valid, halted;
  logic [7:0]  stall_cnt, fetch_cnt;

  logic [31:0] rom [64];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  assign rom_inst = rom[rom_addr];

  inst_fetch_ctrl #(.RESET_PC(6'h01), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .rom_inst(rom_inst), .rom_addr(rom_addr),
    .if_id_inst(if_id_inst), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
    .halted(halted), .stall_cnt(stall_cnt), .fetch_cnt(fetch_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"},  32'(rom_addr),    32'h01);
    chk({tag, "_inst"},  if_id_inst,       32'h0);
    chk({tag, "_pc"},    32'(if_id_pc),    32'h0);
    chk({tag, "_vld"},   32'(if_id_valid), 32'h0);
    chk({tag, "_halt"},  32'(halted),      32'h0);
    chk({tag, "_scnt"},  32'(stall_cnt),   32'h0);
    chk({tag, "_fcnt"},  32'(fetch_cnt),   32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA5000000 | 32'(i);
    rom[6'h01] = 32'h28033046;
    rom[6'h02] = 32'h38000866;
    rom[6'h03] = 32'h14002d29;
    rom[6'h0A] = 32'h00101464;
    rom[6'h3F] = 32'hDEADBEEF;

    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    step(); step();
    chk_reset("rst");

    rst_n = 1'b1;
    step();  // IDLE
    chk("idle_addr", 32'(rom_addr), 32'h01);
    chk("idle_vld",  32'(if_id_valid), 32'h0);
    step();
    chk("f1_inst", if_id_inst, 32'h28033046);
    chk("f1_pc",   32'(if_id_pc), 32'h01);
    chk("f1_vld",  32'(if_id_valid), 32'h1);
    chk("f1_addr", 32'(rom_addr), 32'h02);
    chk("f1_fcnt", 32'(fetch_cnt), 32'h1);
    step();
    chk("f2_inst", if_id_inst, 32'h38000866);
    chk("f2_addr", 32'(rom_addr), 32'h03);

    stall = 1'b1;
    step(); step();
    chk("st_inst", if_id_inst, 32'h38000866);
    chk("st_pc",   32'(if_id_pc), 32'h02);
    chk("st_addr", 32'(rom_addr), 32'h03);
    chk("st_scnt", 32'(stall_cnt), 32'h2);
    chk("st_fcnt", 32'(fetch_cnt), 32'h2);
    stall = 1'b0;
    step();
    chk("rel_inst", if_id_inst, 32'h14002d29);
    chk("rel_pc",   32'(if_id_pc), 32'h03);
    chk("rel_addr", 32'(rom_addr), 32'h04);

    branch_taken = 1'b1; branch_target = 6'h0A; stall = 1'b1;
    step();
    chk("br_vld",  32'(if_id_valid), 32'h0);
    chk("br_inst", if_id_inst, 32'h0);
    chk("br_pc",   32'(if_id_pc), 32'h0);
    chk("br_addr", 32'(rom_addr), 32'h0A);
    chk("br_scnt", 32'(stall_cnt), 32'h2);
    chk("br_fcnt", 32'(fetch_cnt), 32'h3);
    branch_taken = 1'b0; stall = 1'b0;
    step();
    chk("bt_inst", if_id_inst, 32'h00101464);
    chk("bt_pc",   32'(if_id_pc), 32'h0A);
    chk("bt_fcnt", 32'(fetch_cnt), 32'h4);

    branch_taken = 1'b1; branch_target = 6'h3F;
    step();
    chk("end_addr", 32'(rom_addr), 32'h3F);
    branch_taken = 1'b0;
    step();
    chk("end_inst", if_id_inst, 32'hDEADBEEF);
    chk("end_pc",   32'(if_id_pc), 32'h3F);
    chk("end_vld",  32'(if_id_valid), 32'h1);
    chk("end_halt", 32'(halted), 32'h1);
    chk("end_addr2", 32'(rom_addr), 32'h3F);
    chk("end_fcnt", 32'(fetch_cnt), 32'h5);
    stall = 1'b1;
    step();
    chk("h1_vld",  32'(if_id_valid), 32'h0);
    chk("h1_inst", if_id_inst, 32'h0);
    chk("h1_halt", 32'(halted), 32'h1);
    chk("h1_addr", 32'(rom_addr), 32'h3F);
    chk("h1_scnt", 32'(stall_cnt), 32'h2);
    stall = 1'b0;
    step();
    chk("h2_vld",  32'(if_id_valid), 32'h0);
    chk("h2_fcnt", 32'(fetch_cnt), 32'h5);
    branch_taken = 1'b1; branch_target = 6'h01;
    step();
    chk("hb_halt", 32'(halted), 32'h0);
    chk("hb_addr", 32'(rom_addr), 32'h01);
    chk("hb_vld",  32'(if_id_valid), 32'h0);
    branch_taken = 1'b0;
    step();
    chk("hr_inst", if_id_inst, 32'h28033046);
    chk("hr_pc",   32'(if_id_pc), 32'h01);
    chk("hr_fcnt", 32'(fetch_cnt), 32'h6);

    stall = 1'b1;
    step();
    chk("ms_scnt", 32'(stall_cnt), 32'h3);
    rst_n = 1'b0;
    step();
    chk_reset("mrst");
    rst_n = 1'b1; stall = 1'b0;
    step();
    chk("mi_addr", 32'(rom_addr), 32'h01);
    chk("mi_vld",  32'(if_id_valid), 32'h0);
    step();
    chk("mf_inst", if_id_inst, 32'h28033046);
    chk("mf_pc",   32'(if_id_pc), 32'h01);
    chk("mf_fcnt", 32'(fetch_cnt), 32'h1);

    // Loop through the ROM repeatedly (re-branching out of HALT) for well over 255 fetches.
    for (int i = 0; i < 400; i++) begin
      branch_taken  = halted;
      branch_target = 6'h01;
      step();
    end
    chk("sat_fcnt", 32'(fetch_cnt), 32'hFF);

    branch_taken = 1'b1; branch_target = 6'h01;
    step();
    branch_taken = 1'b0; stall = 1'b1;
    for (int i = 0; i < 260; i++) step();
    chk("sat_scnt",  32'(stall_cnt), 32'hFF);
    chk("sat_fcnt2", 32'(fetch_cnt), 32'hFF);
    chk("sat_addr",  32'(rom_addr), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
